// File: rtl/mem_lock_arbiter.sv
// ============================================================================
// Module   : mem_lock_arbiter
// Purpose  : Round-robin arbiter for the shared main_mem port plus the lock table.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_lock_arbiter #(
    parameter  int C  = 8,
    parameter  int NL = 16,
    localparam int IW = (C > 1) ? $clog2(C) : 1,
    localparam int LW = (NL > 1) ? $clog2(NL) : 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [C-1:0]           main_mem_read_request,
    input  logic [C-1:0]           main_mem_write_request,
    input  logic [C-1:0][15:0]     main_mem_read_adr,
    input  logic [C-1:0][15:0]     main_mem_write_adr,
    input  logic [C-1:0][15:0]     main_mem_write_dat,
    input  logic [C-1:0][LW-1:0]   lock_adr,
    input  logic [C-1:0]           lock_en,
    input  logic [C-1:0]           unlock_en,
    output logic [C-1:0]           main_mem_ac,
    output logic [C-1:0]           lock_ac,
    output logic [15:0]            mem_adr,
    output logic [15:0]            mem_wdat,
    output logic                   mem_we,
    output logic                   mem_re,
    output logic [IW-1:0]          grant_id
);

    function automatic logic [IW-1:0] f_wrap(input logic [IW-1:0] base, input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= 32'(C)) s = s - 32'(C);
        return s[IW-1:0];
    endfunction

    logic [C-1:0]          r_mem_ac;
    logic [C-1:0]          r_lock_ac;
    logic [15:0]           r_adr;
    logic [15:0]           r_wdat;
    logic                  r_we;
    logic                  r_re;
    logic [IW-1:0]         r_gid;
    logic [IW-1:0]         r_mptr;
    logic [IW-1:0]         r_lptr;
    logic [NL-1:0]         r_lv;
    logic [NL-1:0][IW-1:0] r_lo;

    logic [C-1:0]          w_mem_elig;
    logic                  w_mem_found;
    logic [IW-1:0]         w_mem_k;
    logic [NL-1:0]         w_lv;
    logic [C-1:0]          w_lk_elig;
    logic                  w_lk_found;
    logic [IW-1:0]         w_lk_k;

    assign main_mem_ac = r_mem_ac;
    assign lock_ac     = r_lock_ac;
    assign mem_adr     = r_adr;
    assign mem_wdat    = r_wdat;
    assign mem_we      = r_we;
    assign mem_re      = r_re;
    assign grant_id    = r_gid;

    // A core inside its grant cycle still shows its request, so it is masked here.
    assign w_mem_elig = (main_mem_read_request | main_mem_write_request) & ~r_mem_ac;

    always_comb begin
        w_mem_found = 1'b0;
        w_mem_k     = '0;
        for (int j = 0; j < C; j++) begin
            if (!w_mem_found && w_mem_elig[f_wrap(r_mptr, j)]) begin
                w_mem_found = 1'b1;
                w_mem_k     = f_wrap(r_mptr, j);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mem_ac <= '0;
            r_adr    <= '0;
            r_wdat   <= '0;
            r_we     <= 1'b0;
            r_re     <= 1'b0;
            r_gid    <= '0;
            r_mptr   <= '0;
        end else begin
            r_mem_ac <= '0;
            r_we     <= 1'b0;
            r_re     <= 1'b0;
            if (w_mem_found) begin
                r_mem_ac[w_mem_k] <= 1'b1;
                r_gid             <= w_mem_k;
                r_mptr            <= f_wrap(w_mem_k, 1);
                if (main_mem_write_request[w_mem_k]) begin
                    r_we   <= 1'b1;
                    r_adr  <= main_mem_write_adr[w_mem_k];
                    r_wdat <= main_mem_write_dat[w_mem_k];
                end else begin
                    r_re   <= 1'b1;
                    r_adr  <= main_mem_read_adr[w_mem_k];
                end
            end
        end
    end

    // Table validity after this cycle's owner unlocks; grantability looks at this view.
    always_comb begin
        w_lv = r_lv;
        for (int i = 0; i < C; i++) begin
            if (unlock_en[i] && r_lv[lock_adr[i]] && (r_lo[lock_adr[i]] == IW'(i)))
                w_lv[lock_adr[i]] = 1'b0;
        end
    end

    always_comb begin
        w_lk_elig = '0;
        for (int i = 0; i < C; i++) begin
            w_lk_elig[i] = lock_en[i] && !r_lock_ac[i] &&
                           (!w_lv[lock_adr[i]] || (r_lo[lock_adr[i]] == IW'(i)));
        end
    end

    always_comb begin
        w_lk_found = 1'b0;
        w_lk_k     = '0;
        for (int j = 0; j < C; j++) begin
            if (!w_lk_found && w_lk_elig[f_wrap(r_lptr, j)]) begin
                w_lk_found = 1'b1;
                w_lk_k     = f_wrap(r_lptr, j);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lock_ac <= '0;
            r_lptr    <= '0;
            r_lv      <= '0;
            r_lo      <= '0;
        end else begin
            r_lock_ac <= '0;
            r_lv      <= w_lv;
            if (w_lk_found) begin
                r_lock_ac[w_lk_k]      <= 1'b1;
                r_lv[lock_adr[w_lk_k]] <= 1'b1;
                r_lo[lock_adr[w_lk_k]] <= w_lk_k;
                r_lptr                 <= f_wrap(w_lk_k, 1);
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_lock_arbiter.sv
// ============================================================================
// Module   : tb_mem_lock_arbiter
// Purpose  : Directed and randomized checks of mem_lock_arbiter against a reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mem_lock_arbiter;

    logic            clk;
    logic            reset_n;
    logic [7:0]      rrq, wrq, len, uen;
    logic [7:0][15:0] radr, wadr, wdat;
    logic [7:0][3:0] ladr;
    logic [7:0]      main_mem_ac, lock_ac;
    logic [15:0]     mem_adr, mem_wdat;
    logic            mem_we, mem_re;
    logic [2:0]      grant_id;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int          m_mptr, m_lptr;
    bit          m_valid[16];
    int          m_owner[16];
    logic [7:0]  e_ac, e_lac;
    int          e_gid;
    logic [15:0] e_adr, e_wdat;
    bit          e_we, e_re;

    mem_lock_arbiter #(.C(8), .NL(16)) dut (
        .clk                    (clk),
        .reset_n                (reset_n),
        .main_mem_read_request  (rrq),
        .main_mem_write_request (wrq),
        .main_mem_read_adr      (radr),
        .main_mem_write_adr     (wadr),
        .main_mem_write_dat     (wdat),
        .lock_adr               (ladr),
        .lock_en                (len),
        .unlock_en              (uen),
        .main_mem_ac            (main_mem_ac),
        .lock_ac                (lock_ac),
        .mem_adr                (mem_adr),
        .mem_wdat               (mem_wdat),
        .mem_we                 (mem_we),
        .mem_re                 (mem_re),
        .grant_id               (grant_id)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_mptr = 0; m_lptr = 0;
        for (int i = 0; i < 16; i++) begin m_valid[i] = 0; m_owner[i] = 0; end
        e_ac = '0; e_lac = '0; e_gid = 0; e_adr = '0; e_wdat = '0; e_we = 0; e_re = 0;
    endtask

    task automatic clear_inputs();
        rrq = '0; wrq = '0; len = '0; uen = '0;
        radr = '0; wadr = '0; wdat = '0; ladr = '0;
    endtask

    task automatic chk_all(input string pfx);
        chk({pfx, "_ac"},   32'(main_mem_ac), 32'(e_ac));
        chk({pfx, "_lac"},  32'(lock_ac),     32'(e_lac));
        chk({pfx, "_adr"},  32'(mem_adr),     32'(e_adr));
        chk({pfx, "_wdat"}, 32'(mem_wdat),    32'(e_wdat));
        chk({pfx, "_we"},   32'(mem_we),      32'(e_we));
        chk({pfx, "_re"},   32'(mem_re),      32'(e_re));
        chk({pfx, "_gid"},  32'(grant_id),    32'(e_gid));
    endtask

    // Predict one clock of behaviour from the current inputs, advance, compare,
    // then let the modelled cores react to their grants.
    task automatic step(input string pfx);
        int k;
        logic [7:0] nac, nlac;
        k = -1;
        for (int j = 0; j < 8; j++) begin
            int i;
            i = (m_mptr + j) % 8;
            if (k < 0 && (rrq[i] || wrq[i]) && !e_ac[i]) k = i;
        end
        nac = '0;
        if (k >= 0) begin
            nac[k] = 1'b1;
            e_gid  = k;
            m_mptr = (k + 1) % 8;
            if (wrq[k]) begin
                e_we = 1; e_re = 0; e_adr = wadr[k]; e_wdat = wdat[k];
            end else begin
                e_we = 0; e_re = 1; e_adr = radr[k];
            end
        end else begin
            e_we = 0; e_re = 0;
        end
        for (int i = 0; i < 8; i++)
            if (uen[i] && m_valid[ladr[i]] && m_owner[ladr[i]] == i) m_valid[ladr[i]] = 0;
        k = -1;
        for (int j = 0; j < 8; j++) begin
            int i;
            i = (m_lptr + j) % 8;
            if (k < 0 && len[i] && !e_lac[i] && (!m_valid[ladr[i]] || m_owner[ladr[i]] == i)) k = i;
        end
        nlac = '0;
        if (k >= 0) begin
            nlac[k] = 1'b1;
            m_valid[ladr[k]] = 1;
            m_owner[ladr[k]] = k;
            m_lptr = (k + 1) % 8;
        end
        e_ac = nac; e_lac = nlac;
        @(posedge clk); #1;
        chk_all(pfx);
        for (int i = 0; i < 8; i++) begin
            if (e_ac[i]) begin
                if (e_we) wrq[i] = 1'b0; else rrq[i] = 1'b0;
            end
            if (e_lac[i]) len[i] = 1'b0;
        end
        uen = '0;
    endtask

    task automatic do_reset(input bit keep_inputs);
        reset_n = 1'b0;
        model_clear();
        if (!keep_inputs) clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        chk_all("rst");
        reset_n = 1'b1;
    endtask

    initial begin
        logic [7:0] rr_seq [6];
        reset_n = 1'b0;
        clear_inputs();
        model_clear();

        // Reset with every request asserted; first grants go to core 0
        rrq = 8'hFF; wrq = 8'hFF; len = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            ladr[i] = 4'(i); radr[i] = 16'(i + 16'h100); wadr[i] = 16'(i + 16'h200);
            wdat[i] = 16'(i + 16'hA00);
        end
        do_reset(1);
        step("first");
        chk("first_ac0", 32'(main_mem_ac), 32'h01);
        chk("first_lac0", 32'(lock_ac), 32'h01);
        step("second");
        do_reset(0);

        // Round-robin among persistent readers 2, 5, 7
        rr_seq = '{8'h04, 8'h20, 8'h80, 8'h04, 8'h20, 8'h80};
        radr[2] = 16'h0002; radr[5] = 16'h0005; radr[7] = 16'h0007;
        for (int n = 0; n < 6; n++) begin
            rrq[2] = 1'b1; rrq[5] = 1'b1; rrq[7] = 1'b1;
            step("rr");
            chk("rr_seq_ac", 32'(main_mem_ac), 32'(rr_seq[n]));
            chk("rr_seq_re", 32'(mem_re), 32'h1);
        end
        rrq = '0;
        step("rr_idle");
        chk("rr_idle_ac", 32'(main_mem_ac), 32'h0);

        // Write served before read for a core asserting both
        wrq[3] = 1'b1; rrq[3] = 1'b1;
        wadr[3] = 16'h0010; wdat[3] = 16'hBEEF; radr[3] = 16'h0020;
        step("wp1");
        chk("wp1_we", 32'(mem_we), 32'h1);
        chk("wp1_adr", 32'(mem_adr), 32'h0010);
        chk("wp1_wdat", 32'(mem_wdat), 32'hBEEF);
        step("wp2");
        chk("wp2_ac", 32'(main_mem_ac), 32'h0);
        step("wp3");
        chk("wp3_re", 32'(mem_re), 32'h1);
        chk("wp3_adr", 32'(mem_adr), 32'h0020);
        chk("wp3_wdat", 32'(mem_wdat), 32'hBEEF);

        // Lock contention on entry 9
        do_reset(0);
        len[1] = 1'b1; ladr[1] = 4'd9; len[4] = 1'b1; ladr[4] = 4'd9;
        step("lk1");
        chk("lk1_lac", 32'(lock_ac), 32'h02);
        step("lk2");
        chk("lk2_lac", 32'(lock_ac), 32'h00);
        uen[1] = 1'b1;
        step("lk3");
        chk("lk3_lac", 32'(lock_ac), 32'h10);

        // Non-owner unlock is ignored
        uen[6] = 1'b1; ladr[6] = 4'd9; len[0] = 1'b1; ladr[0] = 4'd9;
        step("no1");
        chk("no1_lac", 32'(lock_ac), 32'h00);
        step("no2");
        chk("no2_lac", 32'(lock_ac), 32'h00);
        uen[4] = 1'b1;
        step("no3");
        chk("no3_lac", 32'(lock_ac), 32'h01);
        uen[0] = 1'b1;
        step("no4");

        // Asynchronous reset during a write grant
        len[2] = 1'b1; ladr[2] = 4'd5;
        wrq[1] = 1'b1; wadr[1] = 16'h1234; wdat[1] = 16'h5678;
        step("ar1");
        chk("ar1_we", 32'(mem_we), 32'h1);
        #2 reset_n = 1'b0;
        #1;
        chk("ar_we_async", 32'(mem_we), 32'h0);
        chk("ar_ac_async", 32'(main_mem_ac), 32'h0);
        do_reset(0);
        len[3] = 1'b1; ladr[3] = 4'd5;
        step("ar2");
        chk("ar2_lac", 32'(lock_ac), 32'h08);

        // Randomized traffic against the model
        do_reset(0);
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 8; i++) begin
                if (!rrq[i] && $urandom_range(3) == 0) begin
                    rrq[i] = 1'b1; radr[i] = 16'($urandom);
                end
                if (!wrq[i] && $urandom_range(4) == 0) begin
                    wrq[i] = 1'b1; wadr[i] = 16'($urandom); wdat[i] = 16'($urandom);
                end
                if (!len[i]) begin
                    int r;
                    r = $urandom_range(9);
                    if (r == 0) begin
                        len[i] = 1'b1; ladr[i] = 4'($urandom_range(3));
                    end else if (r < 3) begin
                        uen[i] = 1'b1; ladr[i] = 4'($urandom_range(3));
                    end
                end
            end
            step("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
